// File: rtl/hazard_if.sv
// Decode/execute view consumed by the hazard controller and the control
// signals it returns to the F/D and D/E pipeline registers.
interface hazard_if;
  logic        d_in_valid;
  logic [4:0]  d_in_r1_key;
  logic [4:0]  d_in_r2_key;
  logic        d_in_uses_r1;
  logic        d_in_uses_r2;
  logic        ex_in_valid;
  logic [4:0]  ex_in_rd_key;
  logic        ex_in_rd_we;
  logic        ex_in_is_load;
  logic        ex_in_is_mul;
  logic        ex_in_redirect;
  logic        hz_out_stall_fd;
  logic        hz_out_hold_de;
  logic        hz_out_bubble_de;
  logic        hz_out_flush_fd;
  logic        hz_out_mul_busy;
  logic        hz_out_mul_done;
  logic [31:0] hz_out_stall_cnt;

  // Pipeline side drives decode/execute info and consumes the controls.
  modport master (
    output d_in_valid, d_in_r1_key, d_in_r2_key, d_in_uses_r1, d_in_uses_r2,
    output ex_in_valid, ex_in_rd_key, ex_in_rd_we, ex_in_is_load,
    output ex_in_is_mul, ex_in_redirect,
    input  hz_out_stall_fd, hz_out_hold_de, hz_out_bubble_de, hz_out_flush_fd,
    input  hz_out_mul_busy, hz_out_mul_done, hz_out_stall_cnt
  );

  modport slave (
    input  d_in_valid, d_in_r1_key, d_in_r2_key, d_in_uses_r1, d_in_uses_r2,
    input  ex_in_valid, ex_in_rd_key, ex_in_rd_we, ex_in_is_load,
    input  ex_in_is_mul, ex_in_redirect,
    output hz_out_stall_fd, hz_out_hold_de, hz_out_bubble_de, hz_out_flush_fd,
    output hz_out_mul_busy, hz_out_mul_done, hz_out_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Interlock/flush controller for the 5-stage RV32 pipeline: load-use stall,
// multi-cycle MUL occupancy of EX, branch/JAL flush, and a stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  hazard_if.slave hz
);

  localparam int unsigned CNT_W    = $clog2(MUL_LATENCY) + 1;
  localparam bit          MULTI    = (MUL_LATENCY > 1);
  localparam int unsigned LOAD_INT = MULTI ? (MUL_LATENCY - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_INT[CNT_W-1:0];

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic redirect_v;
  logic mul_start;
  logic r1_hit, r2_hit;
  logic load_use;

  logic stall_fd, hold_de, bubble_de, flush_fd, mul_busy, mul_done;

  // A redirecting instruction is never treated as a MUL, so it cannot start the sequencer.
  assign redirect_v = hz.ex_in_valid & hz.ex_in_redirect;
  assign mul_start  = hz.ex_in_valid & hz.ex_in_is_mul & ~redirect_v;

  assign r1_hit   = hz.d_in_uses_r1 & (hz.d_in_r1_key == hz.ex_in_rd_key);
  assign r2_hit   = hz.d_in_uses_r2 & (hz.d_in_r2_key == hz.ex_in_rd_key);
  assign load_use = hz.ex_in_valid & hz.ex_in_is_load & hz.ex_in_rd_we &
                    (hz.ex_in_rd_key != 5'd0) & hz.d_in_valid & (r1_hit | r2_hit);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; async reset lives in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mul_start && MULTI) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controls are Mealy; held at zero for as long as reset is asserted.
  always_comb begin
    stall_fd  = 1'b0;
    hold_de   = 1'b0;
    bubble_de = 1'b0;
    flush_fd  = 1'b0;
    mul_busy  = 1'b0;
    mul_done  = 1'b0;
    if (rst_n) begin
      mul_busy = (state_q == BUSY);
      if (redirect_v) begin
        flush_fd  = 1'b1;
        bubble_de = 1'b1;
      end else if (state_q == BUSY) begin
        if (cnt_q != '0) begin
          stall_fd = 1'b1;
          hold_de  = 1'b1;
        end else begin
          mul_done = 1'b1;
        end
      end else if (mul_start) begin
        if (MULTI) begin
          stall_fd = 1'b1;
          hold_de  = 1'b1;
        end else begin
          mul_done = 1'b1;
        end
      end else if (load_use) begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
      end
    end
  end

  assign stall_cnt_d = stall_cnt_q + {31'd0, stall_fd};

  assign hz.hz_out_stall_fd  = stall_fd;
  assign hz.hz_out_hold_de   = hold_de;
  assign hz.hz_out_bubble_de = bubble_de;
  assign hz.hz_out_flush_fd  = flush_fd;
  assign hz.hz_out_mul_busy  = mul_busy;
  assign hz.hz_out_mul_done  = mul_done;
  assign hz.hz_out_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// MUL/reset/wrap sequences, and randomized traffic against a behavioural model.
module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_if hz();
  hazard_if hz1();

  hazard_ctrl #(.MUL_LATENCY(LAT)) dut  (.clk(clk), .rst_n(rst_n), .hz(hz));
  hazard_ctrl #(.MUL_LATENCY(1))   dut1 (.clk(clk), .rst_n(rst_n), .hz(hz1));

  typedef struct packed {
    logic       dv;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       u1;
    logic       u2;
    logic       ev;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mul;
    logic       rdr;
  } in_t;

  // e = {stall_fd, hold_de, bubble_de, flush_fd, mul_busy, mul_done}
  typedef struct {
    string      name;
    in_t        i;
    logic [5:0] e;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] cnt_exp = '0;
  int          mul_age = -1;   // cycles the current MUL has already spent in EX; -1 = none

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic in_t mk(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                             input logic u1, input logic u2, input logic ev,
                             input logic [4:0] rd, input logic we, input logic ld,
                             input logic mul, input logic rdr);
    in_t t;
    t = '{dv: dv, r1: r1, r2: r2, u1: u1, u2: u2, ev: ev, rd: rd,
          we: we, ld: ld, mul: mul, rdr: rdr};
    return t;
  endfunction

  task automatic drive(input in_t i);
    hz.d_in_valid     = i.dv;
    hz.d_in_r1_key    = i.r1;
    hz.d_in_r2_key    = i.r2;
    hz.d_in_uses_r1   = i.u1;
    hz.d_in_uses_r2   = i.u2;
    hz.ex_in_valid    = i.ev;
    hz.ex_in_rd_key   = i.rd;
    hz.ex_in_rd_we    = i.we;
    hz.ex_in_is_load  = i.ld;
    hz.ex_in_is_mul   = i.mul;
    hz.ex_in_redirect = i.rdr;
  endtask

  task automatic drive1(input in_t i);
    hz1.d_in_valid     = i.dv;
    hz1.d_in_r1_key    = i.r1;
    hz1.d_in_r2_key    = i.r2;
    hz1.d_in_uses_r1   = i.u1;
    hz1.d_in_uses_r2   = i.u2;
    hz1.ex_in_valid    = i.ev;
    hz1.ex_in_rd_key   = i.rd;
    hz1.ex_in_rd_we    = i.we;
    hz1.ex_in_is_load  = i.ld;
    hz1.ex_in_is_mul   = i.mul;
    hz1.ex_in_redirect = i.rdr;
  endtask

  function automatic logic [5:0] outs();
    return {hz.hz_out_stall_fd, hz.hz_out_hold_de, hz.hz_out_bubble_de,
            hz.hz_out_flush_fd, hz.hz_out_mul_busy, hz.hz_out_mul_done};
  endfunction

  function automatic logic [5:0] outs1();
    return {hz1.hz_out_stall_fd, hz1.hz_out_hold_de, hz1.hz_out_bubble_de,
            hz1.hz_out_flush_fd, hz1.hz_out_mul_busy, hz1.hz_out_mul_done};
  endfunction

  // Behavioural model: a MUL occupies EX for lat cycles (age 0..lat-1); stalls on all but the last.
  function automatic logic [5:0] model(input in_t i, input int age, input int lat);
    logic redir, lu, mul_now;
    int   a;
    logic [5:0] e;
    redir   = i.ev & i.rdr;
    mul_now = (age >= 0) || (i.ev && i.mul && !redir);
    a       = (age < 0) ? 0 : age;
    lu      = i.ev & i.ld & i.we & (i.rd != 5'd0) & i.dv &
              ((i.u1 & (i.r1 == i.rd)) | (i.u2 & (i.r2 == i.rd)));
    e = '0;
    e[1] = (age >= 0);
    if (redir)        e[3:2] = 2'b11;
    else if (mul_now) begin
      if (a < lat - 1) e[5:4] = 2'b11;
      else             e[0]   = 1'b1;
    end else if (lu)  e[5:2] = 4'b1010;
    return e;
  endfunction

  function automatic int next_age(input in_t i, input int age, input int lat);
    logic redir;
    int   a;
    redir = i.ev & i.rdr;
    a     = (age < 0) ? 0 : age;
    if (((age >= 0) || (i.ev && i.mul && !redir)) && (a < lat - 1)) return a + 1;
    return -1;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step_exp(input in_t i, input logic [5:0] e, input string nm);
    drive(i);
    @(negedge clk);
    check(nm, {26'd0, outs()}, {26'd0, e});
    check({nm, "_cnt"}, hz.hz_out_stall_cnt, cnt_exp);
    @(posedge clk);
    cnt_exp += {31'd0, e[5]};
    mul_age  = next_age(i, mul_age, LAT);
    #1;
  endtask

  vec_t vt[$];
  in_t  idle, lw5_add, mulx, ri;

  initial begin
    idle    = '0;
    lw5_add = mk(1, 5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 1, 0, 0);
    mulx    = mk(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 1, 0, 1, 0);

    vt.push_back('{"lu_rs1",        lw5_add,                                         6'b101000});
    vt.push_back('{"lu_rd_x0",      mk(1, 5'd0, 5'd7, 1, 1, 1, 5'd0, 1, 1, 0, 0),   6'b000000});
    vt.push_back('{"lu_rs2",        mk(1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 1, 1, 0, 0),   6'b101000});
    vt.push_back('{"rs2_unused",    mk(1, 5'd1, 5'd5, 1, 0, 1, 5'd5, 1, 1, 0, 0),   6'b000000});
    vt.push_back('{"load_no_we",    mk(1, 5'd5, 5'd7, 1, 1, 1, 5'd5, 0, 1, 0, 0),   6'b000000});
    vt.push_back('{"ex_invalid",    mk(1, 5'd5, 5'd7, 1, 1, 0, 5'd5, 1, 1, 0, 0),   6'b000000});
    vt.push_back('{"d_invalid",     mk(0, 5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 1, 0, 0),   6'b000000});
    vt.push_back('{"alu_no_stall",  mk(1, 5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 0, 0, 0),   6'b000000});
    vt.push_back('{"beq_vs_lu",     mk(1, 5'd5, 5'd7, 1, 1, 1, 5'd5, 0, 0, 0, 1),   6'b000100});
    vt.push_back('{"redir_load_lu", mk(1, 5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 1, 0, 1),   6'b001100});
    vt.push_back('{"redir_invalid", mk(1, 5'd5, 5'd7, 1, 1, 0, 5'd5, 1, 1, 0, 1),   6'b000000});
    vt.push_back('{"redir_and_mul", mk(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 1, 0, 1, 1),   6'b001100});
    vt.push_back('{"idle_after",    idle,                                            6'b000000});
    // beq_vs_lu and redir_* also raise bubble_de; fix the expected bits here.
    vt[8].e = 6'b001100;

    // Reset: controls forced low even with an LU pattern present.
    rst_n = 1'b0;
    drive(lw5_add);
    drive1(lw5_add);
    #3;
    check("rst_ctl",  {26'd0, outs()}, 32'd0);
    check("rst_cnt",  hz.hz_out_stall_cnt, 32'd0);
    check("rst_ctl1", {26'd0, outs1()}, 32'd0);
    drive1(idle);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vt[k]) step_exp(vt[k].i, vt[k].e, vt[k].name);
    check("cnt_after_table", hz.hz_out_stall_cnt, 32'd2);

    // Single MUL, then back-to-back MULs, then a dependent load-use after done.
    for (int rep = 0; rep < 3; rep++)
      for (int k = 0; k < LAT; k++)
        step_exp(mulx, {(k < LAT-1), (k < LAT-1), 2'b00, (k > 0), (k == LAT-1)},
                 $sformatf("mul%0d_c%0d", rep, k));
    step_exp(lw5_add, 6'b101000, "lu_after_mul");
    step_exp(idle,    6'b000000, "idle_after_mul");
    check("cnt_mul", hz.hz_out_stall_cnt, 32'd2 + 32'd9 + 32'd1);

    // Reset in the 2nd BUSY cycle: immediate zeroing, no mul_done afterwards.
    step_exp(mulx, 6'b110000, "rstmul_c0");
    step_exp(mulx, 6'b110010, "rstmul_c1");
    drive(mulx);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst_ctl", {26'd0, outs()}, 32'd0);
    check("midmul_rst_cnt", hz.hz_out_stall_cnt, 32'd0);
    @(posedge clk); #1;
    drive(idle);
    rst_n   = 1'b1;
    mul_age = -1;
    cnt_exp = '0;
    step_exp(idle, 6'b000000, "post_rst_idle");
    step_exp(idle, 6'b000000, "post_rst_idle2");

    // MUL_LATENCY = 1 instance: done in first cycle, no stall; counter wrap.
    drive1(mulx);
    @(negedge clk);
    check("l1_mul", {26'd0, outs1()}, 32'b000001);
    @(posedge clk); #1;
    drive1(idle);
    @(negedge clk);
    check("l1_after_mul", {26'd0, outs1()}, 32'd0);
    check("l1_cnt0", hz1.hz_out_stall_cnt, 32'd0);
    @(posedge clk); #1;
    force dut1.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut1.stall_cnt_q;
    drive1(lw5_add);
    @(negedge clk);
    check("l1_lu_a",  {26'd0, outs1()}, 32'b101000);
    check("l1_cnt_a", hz1.hz_out_stall_cnt, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    @(negedge clk);
    check("l1_cnt_b", hz1.hz_out_stall_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive1(idle);
    @(negedge clk);
    check("l1_cnt_wrap", hz1.hz_out_stall_cnt, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic; EX is held steady while a MUL occupies it.
    ri = idle;
    for (int n = 0; n < 400; n++) begin
      int kind;
      ri.dv = ($urandom_range(0, 7) != 0);
      ri.r1 = 5'($urandom_range(0, 3));
      ri.r2 = 5'($urandom_range(0, 3));
      ri.u1 = 1'($urandom_range(0, 1));
      ri.u2 = 1'($urandom_range(0, 1));
      if (mul_age < 0) begin
        kind   = $urandom_range(0, 9);
        ri.ev  = ($urandom_range(0, 7) != 0);
        ri.rd  = 5'($urandom_range(0, 3));
        ri.we  = ($urandom_range(0, 5) != 0);
        ri.ld  = (kind <= 2);
        ri.mul = (kind == 3 || kind == 4);
        ri.rdr = (kind == 5);
      end
      step_exp(ri, model(ri, mul_age, LAT), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock and flush controller for the 5-stage RV32 core. It sits beside the decode stage and the ID/EX register. It compares the source registers of the instruction in decode against the instruction held in execute. From that it generates stall, hold, bubble and flush controls for the F/D and D/E pipeline registers. It also sequences multi-cycle MUL occupancy of the ALU and counts stall cycles for performance monitoring.

## Interface
Parameters:
- MUL_LATENCY, 4, total cycles a MUL occupies EX (≥1)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_in_valid  in  1  decode holds a valid instruction
- d_in_r1_key  in  5  rs1 index from decode
- d_in_r2_key  in  5  rs2 index from decode
- d_in_uses_r1  in  1  decode instruction reads rs1
- d_in_uses_r2  in  1  decode instruction reads rs2
- ex_in_valid  in  1  D/E register holds a valid instruction
- ex_in_rd_key  in  5  rd of EX instruction
- ex_in_rd_we  in  1  EX instruction writes rd
- ex_in_is_load  in  1  EX instruction is LW/LB (rd_sel == 2'b01)
- ex_in_is_mul  in  1  EX alu_op == ALU_MUL
- ex_in_redirect  in  1  EX resolved a taken branch or a JAL
- hz_out_stall_fd  out  1  hold PC and F/D register
- hz_out_hold_de  out  1  hold D/E register contents
- hz_out_bubble_de  out  1  load NOP into D/E
- hz_out_flush_fd  out  1  load NOP into F/D
- hz_out_mul_busy  out  1  MUL sequencer not IDLE
- hz_out_mul_done  out  1  final EX cycle of current MUL
- hz_out_stall_cnt  out  32  cycles with hz_out_stall_fd = 1

## Operation
- Reset: clock and reset are fixed. One clock `clk`; reset `rst_n` is asynchronous and active-low. While rst_n = 0:
  - state = IDLE, mul counter = 0, hz_out_stall_cnt = 0.
  - All control outputs are forced to 0.
- Load-use hazard (LU) is defined as:
  - ex_in_valid & ex_in_is_load & ex_in_rd_we & (ex_in_rd_key != 0) & d_in_valid
  - & ((d_in_uses_r1 & r1 == rd) | (d_in_uses_r2 & r2 == rd)).
  - Response: stall_fd = 1, bubble_de = 1 for exactly one cycle. After the bubble the load has left EX, so LU clears.
- MUL sequencer, states IDLE and BUSY, counter width $clog2(MUL_LATENCY)+1:
  - IDLE, ex_in_valid & ex_in_is_mul, MUL_LATENCY = 1: mul_done = 1, no stall, stay IDLE.
  - IDLE, same condition, MUL_LATENCY > 1: stall_fd = 1, hold_de = 1. Load cnt = MUL_LATENCY-2 and go to BUSY.
  - BUSY, cnt != 0: stall_fd = 1, hold_de = 1, cnt--.
  - BUSY, cnt == 0: mul_done = 1, no stall, go to IDLE.
  - mul_busy = (state == BUSY).
- Redirect: ex_in_redirect & ex_in_valid gives flush_fd = 1, bubble_de = 1, stall_fd = 0 for one cycle. PC redirect is external.
- Priority: redirect > MUL > LU.
  - Redirect and MUL are mutually exclusive in EX; if both are asserted, redirect wins and the sequencer does not start.
  - hold_de and bubble_de are never both 1.
- Back-to-back MULs: the cycle after mul_done, IDLE sees the new MUL and restarts. No gap cycle.
- MUL followed by a dependent load-use: LU is evaluated only once state is IDLE and the load is in EX.
- Stall counter: increments by 1 every cycle hz_out_stall_fd = 1, wraps modulo 2^32.

## Timing
- All control outputs are Mealy and combinational from the inputs, the state and the counter. They are valid within the same cycle for the pipeline registers to sample on the next edge.
- The state, cnt and hz_out_stall_cnt registers update on the rising edge of clk.
- A MUL entering EX at cycle t:
  - stall_fd = 1 in cycles t..t+MUL_LATENCY-2.
  - mul_done = 1 at t+MUL_LATENCY-1.
  - The next instruction enters EX at t+MUL_LATENCY.
- LU costs exactly 1 cycle. Redirect costs 2 cycles (two NOPs).
- If rst_n is asserted mid-MUL, the sequencer returns to IDLE immediately and asynchronously; no mul_done is issued.
- Inputs are assumed glitch-free at the clock edge; there are no combinational paths from outputs back to inputs inside the block.

## Test plan
- LW x5 in EX, ADD x6,x5,x7 in decode → stall_fd = 1, bubble_de = 1 for 1 cycle, stall_cnt 0→1; same case with rd = x0 → no stall.
- MUL in EX, MUL_LATENCY = 4 → stall_fd/hold_de high 3 cycles, mul_done high in cycle 4, mul_busy high cycles 2–4 → wait, busy high cycles 2–4 only while in BUSY; check stall_cnt = 3.
- Two consecutive MULs → 3 stalls, done, 3 stalls, done; no idle cycle between them; stall_cnt = 6.
- Taken BEQ in EX together with a coincident LU pattern on the decode inputs → flush_fd = 1, bubble_de = 1, stall_fd = 0.
- rst_n low at the 2nd BUSY cycle → all outputs 0 immediately; after release with no MUL in EX → IDLE, no mul_done.
- MUL_LATENCY = 1 build → MUL gives mul_done = 1 in its first cycle, zero stalls; stall_cnt preloaded near 0xFFFFFFFF by forcing stalls → wraps to 0.
